// File: rtl/mul_hilo_ctrl_pkg.sv
// mul_hilo_ctrl_pkg: shared state encoding and sizing helpers for the HI/LO multiply sequencer
package mul_hilo_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: latches operands for the combinational multiplier, waits a settle window, captures HI/LO
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a_in,
  input  logic [DATA_W-1:0]   b_in,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  input  logic [2*DATA_W-1:0] product_in,
  output logic                busy,
  output logic                done,
  input  logic                hi_wr,
  input  logic                lo_wr,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out
);
  localparam int CW = cnt_width(SETTLE_CYCLES);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic accept, capture, bus_ok;
  always_comb begin
    bus_ok   = state != SETTLE;
    accept   = start && bus_ok;
    capture  = state == SETTLE && cnt == '0;
    busy     = state == SETTLE;
    done     = state == DONE;
    state_nx = accept ? SETTLE : capture ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (accept) cnt <= CW'(SETTLE_CYCLES - 1);
    else if (busy && cnt != '0) cnt <= cnt - CW'(1);
  // Operands move only on an accepted start so the multiplier sees stable inputs while settling.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= a_in;
      op_b <= b_in;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (capture) begin
      hi_out <= product_in[2*DATA_W-1:DATA_W];
      lo_out <= product_in[DATA_W-1:0];
    end else if (bus_ok) begin
      if (hi_wr) hi_out <= bus_in;
      if (lo_wr) lo_out <= bus_in;
    end
endmodule
